uart_rx_fifo: RTL

Next-generation UART receiver with runtime-configurable baud divisor, data width, parity and stop bits. Uses 16x oversampling with 3-sample majority voting and false-start rejection. Received words carry per-word error sidebands and are buffered in an internal FIFO, read out through a valid/ready stream. It sits between the board RX pin and the CPU-side peripheral register/interrupt logic.

---
 rtl/uart_rx_fifo.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 3-sample majority voting, runtime
// frame configuration, break detection and a registered-output receive FIFO.
module uart_rx_fifo #(
  parameter int Oversample  = 16,
  parameter int DivWidth    = 16,
  parameter int MaxDataBits = 9,
  parameter int FifoDepth   = 8,
  parameter int SyncStages  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DivWidth-1:0]            cfg_divisor,
  input  logic [3:0]                     cfg_data_bits,
  input  logic [1:0]                     cfg_parity,
  input  logic                           cfg_two_stop,
  input  logic                           rx_in,
  output logic [MaxDataBits-1:0]         m_data,
  output logic                           m_parity_err,
  output logic                           m_frame_err,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [$clog2(FifoDepth+1)-1:0] fifo_level,
  output logic                           break_pulse,
  output logic                           overrun_pulse
);

  localparam int OsW   = $clog2(Oversample);
  localparam int CntW  = $clog2(FifoDepth + 1);
  localparam int PtrW  = $clog2(FifoDepth);
  localparam int WordW = MaxDataBits + 2;
  localparam logic [OsW-1:0] OS_LAST = OsW'(Oversample - 1);
  localparam logic [OsW-1:0] SMP_LO  = OsW'(Oversample / 2 - 1);
  localparam logic [OsW-1:0] SMP_HI  = OsW'(Oversample / 2 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_e;

  state_e                 state_q;
  logic [SyncStages-1:0]  sync_q;
  logic [DivWidth-1:0]    div_cnt_q, lat_div_q, div_sel_s, div_eff_s;
  logic [OsW-1:0]         os_cnt_q, brk_cnt_q;
  logic [1:0]             vote_q, lat_par_q;
  logic [3:0]             bit_cnt_q, lat_bits_q;
  logic [MaxDataBits-1:0] shift_q;
  logic                   lat_two_q, stop_idx_q, par_err_q, frm_err_q, all_zero_q;
  logic                   break_pulse_q, overrun_q;
  logic                   line_s, tick_s, start_s, in_win_s, decide_s, bit_end_s, maj_s;
  logic                   frm_err_s, zero_s, last_stop_s, push_s;
  logic [WordW-1:0]       push_word_s;

  logic [WordW-1:0]       mem_q [FifoDepth];
  logic [PtrW-1:0]        wr_q, rd_q, wr_d, rd_d;
  logic [CntW-1:0]        count_q, count_d, remain_s;
  logic [WordW-1:0]       head_q, head_d;
  logic                   valid_q, valid_d, pop_s, full_s, push_ok_s, overrun_s;

  assign line_s = sync_q[SyncStages-1];

  // Bring the asynchronous line into the clock domain; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SyncStages{1'b1}};
    else        sync_q <= {sync_q[SyncStages-2:0], rx_in};
  end

  // Live divisor while idle, latched divisor inside a frame; zero acts as one.
  always_comb begin
    div_sel_s = (state_q == IDLE) ? cfg_divisor : lat_div_q;
    if (div_sel_s == DivWidth'(0)) div_eff_s = DivWidth'(1);
    else                           div_eff_s = div_sel_s;
  end

  assign tick_s      = (div_cnt_q >= div_eff_s - DivWidth'(1));
  assign start_s     = (state_q == IDLE) && !line_s;
  assign in_win_s    = tick_s && (os_cnt_q >= SMP_LO) && (os_cnt_q <= SMP_HI);
  assign decide_s    = tick_s && (os_cnt_q == SMP_HI);
  assign bit_end_s   = tick_s && (os_cnt_q == OS_LAST);
  assign maj_s       = (vote_q == 2'd2) || ((vote_q == 2'd1) && line_s);
  assign frm_err_s   = frm_err_q | ~maj_s;
  assign zero_s      = all_zero_q & ~maj_s;
  assign last_stop_s = (state_q == STOP) && decide_s && (stop_idx_q == lat_two_q);
  assign push_s      = last_stop_s && !zero_s;
  assign push_word_s = {frm_err_s, par_err_q, shift_q};

  // Baud tick generator; restarts on start detection to align with the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_cnt_q <= DivWidth'(0);
    else if (start_s || tick_s) div_cnt_q <= DivWidth'(0);
    else             div_cnt_q <= div_cnt_q + DivWidth'(1);
  end

  // Receive FSM: oversample counting, majority voting, framing and break.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;       os_cnt_q <= OsW'(0);     brk_cnt_q <= OsW'(0);
      vote_q <= 2'd0;        bit_cnt_q <= 4'd0;       shift_q <= MaxDataBits'(0);
      lat_div_q <= DivWidth'(0); lat_bits_q <= 4'd8;  lat_par_q <= 2'd0;
      lat_two_q <= 1'b0;     stop_idx_q <= 1'b0;      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;     all_zero_q <= 1'b1;      break_pulse_q <= 1'b0;
    end else begin
      break_pulse_q <= 1'b0;
      if (tick_s && (state_q != IDLE) && (state_q != BREAK_WAIT)) begin
        os_cnt_q <= (os_cnt_q == OS_LAST) ? OsW'(0) : os_cnt_q + OsW'(1);
        if (decide_s)      vote_q <= 2'd0;
        else if (in_win_s) vote_q <= vote_q + {1'b0, line_s};
      end
      case (state_q)
        IDLE: begin
          if (!line_s) begin
            state_q    <= START;
            os_cnt_q   <= OsW'(0);
            vote_q     <= 2'd0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= MaxDataBits'(0);
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            all_zero_q <= 1'b1;
            stop_idx_q <= 1'b0;
            lat_div_q  <= cfg_divisor;
            lat_two_q  <= cfg_two_stop;
            lat_par_q  <= (cfg_parity == 2'd3) ? 2'd0 : cfg_parity;
            if (cfg_data_bits < 4'd5)      lat_bits_q <= 4'd5;
            else if (cfg_data_bits > 4'd9) lat_bits_q <= 4'd9;
            else                           lat_bits_q <= cfg_data_bits;
          end
        end
        START: begin
          if (decide_s && maj_s) state_q <= IDLE;
          else if (bit_end_s)    state_q <= DATA;
        end
        DATA: begin
          if (decide_s) begin
            shift_q[bit_cnt_q] <= maj_s;
            bit_cnt_q          <= bit_cnt_q + 4'd1;
            all_zero_q         <= zero_s;
          end
          if (bit_end_s && (bit_cnt_q == lat_bits_q))
            state_q <= (lat_par_q != 2'd0) ? PARITY : STOP;
        end
        PARITY: begin
          if (decide_s) begin
            par_err_q  <= (^shift_q ^ maj_s) != (lat_par_q == 2'd2);
            all_zero_q <= zero_s;
          end
          if (bit_end_s) state_q <= STOP;
        end
        STOP: begin
          if (decide_s) begin
            frm_err_q  <= frm_err_s;
            all_zero_q <= zero_s;
            stop_idx_q <= 1'b1;
          end
          if (last_stop_s) begin
            os_cnt_q <= OsW'(0);
            if (zero_s) begin
              break_pulse_q <= 1'b1;
              brk_cnt_q     <= OsW'(0);
              state_q       <= BREAK_WAIT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        BREAK_WAIT: begin
          if (tick_s) begin
            if (!line_s)                    brk_cnt_q <= OsW'(0);
            else if (brk_cnt_q == OS_LAST)  state_q   <= IDLE;
            else                            brk_cnt_q <= brk_cnt_q + OsW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO next state; the head word is precomputed so m_* come straight from flops.
  always_comb begin
    pop_s     = valid_q & m_ready;
    full_s    = (count_q == CntW'(FifoDepth));
    push_ok_s = push_s & (~full_s | pop_s);
    overrun_s = push_s & full_s & ~pop_s;
    count_d   = count_q + CntW'(push_ok_s) - CntW'(pop_s);
    remain_s  = count_q - CntW'(pop_s);
    rd_d      = rd_q + PtrW'(pop_s);
    wr_d      = wr_q + PtrW'(push_ok_s);
    if (remain_s != CntW'(0)) head_d = mem_q[rd_d];
    else if (push_ok_s)       head_d = push_word_s;
    else                      head_d = {WordW{1'b0}};
    valid_d   = (count_d != CntW'(0));
  end

  // FIFO storage; only written on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_q[wr_q] <= push_word_s;
  end

  // FIFO pointers, occupancy, registered head word and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= PtrW'(0); rd_q <= PtrW'(0); count_q <= CntW'(0);
      head_q <= {WordW{1'b0}}; valid_q <= 1'b0; overrun_q <= 1'b0;
    end else begin
      wr_q <= wr_d; rd_q <= rd_d; count_q <= count_d;
      head_q <= head_d; valid_q <= valid_d; overrun_q <= overrun_s;
    end
  end

  assign m_data        = head_q[MaxDataBits-1:0];
  assign m_parity_err  = head_q[MaxDataBits];
  assign m_frame_err   = head_q[MaxDataBits+1];
  assign m_valid       = valid_q;
  assign fifo_level    = count_q;
  assign break_pulse   = break_pulse_q;
  assign overrun_pulse = overrun_q;

endmodule
